// File: rtl/ff_bank_arbiter_if.sv
// Requester-side bus of the shared flip-flop bank arbiter.
// The arbiter takes the slave modport and the requesting FSMs take the master modport.
interface ff_bank_arbiter_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
);
    logic [N-1:0]   req;
    logic [2*N-1:0] op;
    logic [W*N-1:0] arg;
    logic [N-1:0]   grant;
    logic [N-1:0]   ack;
    logic           busy;
    logic [W-1:0]   q;

    modport master (
        output req, op, arg,
        input  grant, ack, busy, q
    );

    modport slave (
        input  req, op, arg,
        output grant, ack, busy, q
    );
endinterface

// File: rtl/ff_bank_arbiter.sv
// Round-robin sequencer that shares one W-bit register bank between N requesters.
// Each grant applies one LOAD/TOGGLE/SET to the bank; all state moves on the falling clock edge.
module ff_bank_arbiter #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
) (
    input logic              clk,
    input logic              reset,
    ff_bank_arbiter_if.slave bus
);
    localparam int unsigned PtrW = $clog2(N);

    typedef enum logic [1:0] {StIdle, StGrant, StExec, StAck} state_e;

    state_e            state_q, state_d;
    logic [PtrW-1:0]   winner_q, winner_d;
    logic [PtrW-1:0]   last_ptr_q, last_ptr_d;
    logic [1:0]        op_q, op_d;
    logic [W-1:0]      arg_q, arg_d;
    logic [W-1:0]      bank_q, bank_d;
    logic [N-1:0]      grant_q, grant_d;
    logic [N-1:0]      ack_q, ack_d;

    logic              pick_valid;
    logic [PtrW-1:0]   pick;
    logic [PtrW-1:0]   cand;
    logic [1:0]        op_sel;
    logic [W-1:0]      arg_sel;

    // Walk from the farthest position back to last_ptr+1 so the nearest requester wins.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        cand       = '0;
        for (int k = N; k >= 1; k--) begin
            cand = PtrW'((int'(last_ptr_q) + k) % N);
            if (bus.req[cand]) begin
                pick_valid = 1'b1;
                pick       = cand;
            end
        end
    end

    always_comb begin
        op_sel  = '0;
        arg_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (winner_q == PtrW'(i)) begin
                op_sel  = bus.op[2*i +: 2];
                arg_sel = bus.arg[W*i +: W];
            end
        end
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (pick_valid) state_d = StGrant;
            StGrant: state_d = bus.req[winner_q] ? StExec : StIdle;
            StExec:  state_d = StAck;
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        winner_d   = winner_q;
        last_ptr_d = last_ptr_q;
        op_d       = op_q;
        arg_d      = arg_q;
        bank_d     = bank_q;
        grant_d    = grant_q;
        ack_d      = '0;
        case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    winner_d = pick;
                    grant_d  = N'(1) << pick;
                end
            end
            StGrant: begin
                // A withdrawn request leaves last_ptr alone so its turn is not consumed.
                if (bus.req[winner_q]) begin
                    op_d  = op_sel;
                    arg_d = arg_sel;
                end else begin
                    grant_d = '0;
                end
            end
            StExec: begin
                case (op_q)
                    2'b01:   bank_d = arg_q;
                    2'b10:   bank_d = bank_q ^ arg_q;
                    2'b11:   bank_d = bank_q | arg_q;
                    default: bank_d = bank_q;
                endcase
            end
            StAck: begin
                ack_d      = N'(1) << winner_q;
                grant_d    = '0;
                last_ptr_d = winner_q;
            end
            default: ;
        endcase
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            winner_q   <= '0;
            last_ptr_q <= PtrW'(N - 1);
            op_q       <= '0;
            arg_q      <= '0;
            bank_q     <= '0;
            grant_q    <= '0;
            ack_q      <= '0;
        end else begin
            winner_q   <= winner_d;
            last_ptr_q <= last_ptr_d;
            op_q       <= op_d;
            arg_q      <= arg_d;
            bank_q     <= bank_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.ack   = ack_q;
    assign bus.busy  = (state_q != StIdle);
    assign bus.q     = bank_q;
endmodule

// File: tb/tb_ff_bank_arbiter.sv
// Randomised scoreboard bench for ff_bank_arbiter: each batch of requests is run through a
// rotation model up front, and a monitor checks every ack pulse against the queued expectation.
module tb_ff_bank_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned PW = $clog2(N);

    typedef struct {
        int           idx;
        logic [W-1:0] q;
    } exp_t;

    logic clk;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    exp_t         sb[$];
    logic [W-1:0] m_q;
    int           m_last;

    ff_bank_arbiter_if #(.N(N), .W(W)) bus ();

    ff_bank_arbiter #(.N(N), .W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ff_op(input logic [1:0] o, input logic [W-1:0] cur,
                                           input logic [W-1:0] a);
        case (o)
            2'd1:    return a;
            2'd2:    return cur ^ a;
            2'd3:    return cur | a;
            default: return cur;
        endcase
    endfunction

    // Every requester in the mask holds until served; serve in rotation after the last winner.
    task automatic model_batch(input logic [N-1:0] mask, input logic [2*N-1:0] ops,
                               input logic [W*N-1:0] args);
        logic [N-1:0] pend;
        int           nxt;
        exp_t         e;
        pend = mask;
        while (pend != '0) begin
            nxt = -1;
            for (int k = 1; k <= N; k++) begin
                if (nxt < 0 && pend[PW'((m_last + k) % N)]) nxt = (m_last + k) % N;
            end
            m_q          = ff_op(2'(ops >> (2 * nxt)), m_q, W'(args >> (W * nxt)));
            pend[PW'(nxt)] = 1'b0;
            m_last       = nxt;
            e.idx        = nxt;
            e.q          = m_q;
            sb.push_back(e);
        end
    endtask

    // Called at posedge+1; each requester drops its req once it has seen its ack.
    task automatic run_batch(input logic [N-1:0] mask, input logic [2*N-1:0] ops,
                             input logic [W*N-1:0] args);
        int cycles;
        model_batch(mask, ops, args);
        bus.req = mask;
        bus.op  = ops;
        bus.arg = args;
        cycles  = 0;
        while (bus.req != '0 && cycles < 16 * N) begin
            @(posedge clk);
            #1;
            cycles++;
            bus.req = bus.req & ~bus.ack;
        end
        check("batch_done", 64'(bus.req), 64'(0));
        check("batch_cycles", 64'(cycles), 64'(4 * $countones(mask)));
        if (bus.req != '0) begin
            bus.req = '0;
            sb.delete();
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        check("grant_onehot0", 64'($onehot0(bus.grant)), 64'(1));
        check("ack_onehot0", 64'($onehot0(bus.ack)), 64'(1));
        if (bus.ack != '0) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ack: got %0h, expected none", bus.ack);
            end else begin
                e = sb.pop_front();
                check("ack_idx", 64'(bus.ack), 64'(N'(1) << e.idx));
                check("ack_q", 64'(bus.q), 64'(e.q));
            end
        end
    end

    initial begin
        logic [N-1:0]   mask;
        logic [2*N-1:0] ops;
        logic [W*N-1:0] args;

        bus.req = '0;
        bus.op  = '0;
        bus.arg = '0;
        reset   = 1'b1;
        m_q     = '0;
        m_last  = N - 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_q", 64'(bus.q), 64'(0));
        check("rst_grant", 64'(bus.grant), 64'(0));
        check("rst_ack", 64'(bus.ack), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single LOAD with cycle-level latency checks.
        model_batch(4'b0001, 8'b0000_0001, 32'h0000_00A5);
        bus.req = 4'b0001;
        bus.op  = 8'b0000_0001;
        bus.arg = 32'h0000_00A5;
        @(posedge clk); #1;
        check("t1_grant", 64'(bus.grant), 64'(4'b0001));
        check("t1_busy", 64'(bus.busy), 64'(1));
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t1_q", 64'(bus.q), 64'(8'hA5));
        check("t1_ack_early", 64'(bus.ack), 64'(0));
        @(posedge clk); #1;
        check("t1_ack", 64'(bus.ack), 64'(4'b0001));
        bus.req = '0;
        @(posedge clk); #1;
        check("t1_ack_fall", 64'(bus.ack), 64'(0));
        check("t1_idle", 64'(bus.busy), 64'(0));

        run_batch(4'b0001, 8'b0000_0010, 32'h0000_000F);
        check("t2_toggle", 64'(bus.q), 64'(8'hAA));
        run_batch(4'b0001, 8'b0000_0011, 32'h0000_0001);
        check("t2_set", 64'(bus.q), 64'(8'hAB));

        run_batch(4'b1111, 8'h00, 32'hDEAD_BEEF);
        run_batch(4'b0100, 8'b0001_0000, 32'h0033_0000);
        run_batch(4'b1101, 8'b1101_0010, 32'h1122_3344);

        // Withdraw during GRANT: no ack, q kept, rotation point kept.
        bus.req = 4'b0010;
        bus.op  = 8'b0000_0100;
        bus.arg = 32'h0000_FF00;
        @(posedge clk); #1;
        check("t5_grant", 64'(bus.grant), 64'(4'b0010));
        bus.req = '0;
        @(posedge clk); #1;
        check("t5_grant_drop", 64'(bus.grant), 64'(0));
        check("t5_busy", 64'(bus.busy), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        check("t5_q", 64'(bus.q), 64'(m_q));
        run_batch(4'b1111, 8'b0110_1001, 32'h0F0F_3C3C);

        // Reset while the LOAD is in EXEC.
        bus.req = 4'b0001;
        bus.op  = 8'b0000_0001;
        bus.arg = 32'h0000_00FF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t6_busy_pre", 64'(bus.busy), 64'(1));
        reset = 1'b1;
        #1;
        check("t6_q", 64'(bus.q), 64'(0));
        check("t6_grant", 64'(bus.grant), 64'(0));
        check("t6_ack", 64'(bus.ack), 64'(0));
        check("t6_busy", 64'(bus.busy), 64'(0));
        @(posedge clk); #1;
        bus.req = '0;
        reset   = 1'b0;
        m_q     = '0;
        m_last  = N - 1;
        @(posedge clk); #1;
        check("t6_q_hold", 64'(bus.q), 64'(0));
        run_batch(4'b1011, 8'b0101_0101, 32'h8040_2010);

        for (int t = 0; t < 40; t++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            ops  = (2 * N)'($urandom);
            args = '0;
            for (int i = 0; i < N; i++) begin
                args = (args << W) | (W * N)'($urandom_range(0, (1 << W) - 1));
            end
            run_batch(mask, ops, args);
        end

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
